// File: rtl/axis_telemetry_framer.sv
// -----------------------------------------------------------------------------
// axis_telemetry_framer
//
// Wraps each 8-bit AXI-Stream packet from the telemetry logger into a frame:
//   SYNC_BYTE, SEQ, payload (kept bytes only), LEN [, CRC-8]
// so the host can resynchronise, spot lost frames by sequence gaps and check
// payload length. Packets longer than MAX_PAYLOAD kept bytes are split: the
// frame is closed early, overrun_o pulses, and the remaining bytes open the
// next frame.
//
// The only storage is one registered output stage. Backpressure from m_tready
// reaches s_tready combinationally; nothing on the slave side feeds m_tvalid
// without passing through a register.
//
// Build option:
//   TELEMETRY_CRC_EN  when defined, a CRC-8 trailer (poly 0x07, init 0x00,
//                     no reflection, no final XOR) over the kept payload bytes
//                     follows LEN and carries m_tlast. When undefined there is
//                     no CRC state at all and m_tlast sits on LEN.
//
// Parameters:
//   SYNC_BYTE    first byte of every frame
//   MAX_PAYLOAD  kept payload bytes per frame before forced termination (1..255)
//
// Ports:
//   clock      single clock domain
//   reset_n    asynchronous active-low reset
//   enable_i   allows a new frame to start (looked at only while idle)
//   s_tvalid   logger byte valid
//   s_tready   framer accepts logger byte (only while in the payload phase)
//   s_tlast    last byte of logger packet
//   s_tkeep    byte qualifier, 0 = discard byte
//   s_tdata    logger byte
//   m_tvalid   framed byte valid
//   m_tready   downstream accept
//   m_tlast    final byte of frame
//   m_tkeep    constant 1
//   m_tdata    framed byte
//   seq_o      sequence number of the next frame
//   overrun_o  one-cycle pulse when a frame is cut at MAX_PAYLOAD
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module axis_telemetry_framer #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_PAYLOAD = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable_i,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  input  logic       s_tkeep,
  input  logic [7:0] s_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic       m_tkeep,
  output logic [7:0] m_tdata,
  output logic [7:0] seq_o,
  output logic       overrun_o
);

  localparam int PBITS = $clog2(MAX_PAYLOAD + 1);

`ifdef TELEMETRY_CRC_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_SEQ  = 3'd2,
    ST_DATA = 3'd3,
    ST_LEN  = 3'd4,
    ST_CRC  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_SEQ  = 3'd2,
    ST_DATA = 3'd3,
    ST_LEN  = 3'd4
  } state_t;
`endif

  state_t             state;
  logic [7:0]         seq;
  logic [PBITS-1:0]   pcnt;
  logic [PBITS-1:0]   pcnt_inc;
  logic               load;
  logic               at_max;
  logic               overrun_p1;

  // Output register stage
  logic               vld_p1;
  logic [7:0]         data_p1;
  logic               last_p1;

`ifdef TELEMETRY_CRC_EN
  logic [7:0]         crc;

  // One byte of CRC-8, MSB first, polynomial x^8 + x^2 + x + 1.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc_in,
                                           input logic [7:0] din);
    logic [7:0] c;
    c = crc_in ^ din;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  // The output register can take a new byte when it is empty or is being
  // drained this cycle; every state advance is gated by this.
  assign load     = !vld_p1 || m_tready;
  assign s_tready = (state == ST_DATA) && load;

  assign pcnt_inc = pcnt + 1'b1;
  // Only a kept byte can fill the frame.
  assign at_max   = s_tkeep && (pcnt_inc == PBITS'(MAX_PAYLOAD));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      seq        <= 8'h00;
      pcnt       <= '0;
      overrun_p1 <= 1'b0;
      vld_p1     <= 1'b0;
      data_p1    <= 8'h00;
      last_p1    <= 1'b0;
`ifdef TELEMETRY_CRC_EN
      crc        <= 8'h00;
`endif
    end else begin
      overrun_p1 <= 1'b0;
      // A byte leaving the register empties it unless a state below refills it.
      if (load) begin
        vld_p1 <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (s_tvalid && enable_i) begin
            state <= ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= SYNC_BYTE;
            last_p1 <= 1'b0;
            state   <= ST_SEQ;
          end
        end

        ST_SEQ: begin
          if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= seq;
            last_p1 <= 1'b0;
            state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (load && s_tvalid) begin
            if (s_tkeep) begin
              vld_p1  <= 1'b1;
              data_p1 <= s_tdata;
              last_p1 <= 1'b0;
              pcnt    <= pcnt_inc;
`ifdef TELEMETRY_CRC_EN
              crc     <= crc8_next(crc, s_tdata);
`endif
            end
            if (s_tlast || at_max) begin
              state <= ST_LEN;
            end
            // A cut without tlast leaves the rest of the packet for the next frame.
            overrun_p1 <= at_max && !s_tlast;
          end
        end

        ST_LEN: begin
          if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= 8'(pcnt);
`ifdef TELEMETRY_CRC_EN
            last_p1 <= 1'b0;
            state   <= ST_CRC;
`else
            last_p1 <= 1'b1;
            seq     <= seq + 8'd1;
            pcnt    <= '0;
            state   <= ST_IDLE;
`endif
          end
        end

`ifdef TELEMETRY_CRC_EN
        ST_CRC: begin
          if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= crc;
            last_p1 <= 1'b1;
            seq     <= seq + 8'd1;
            pcnt    <= '0;
            crc     <= 8'h00;
            state   <= ST_IDLE;
          end
        end
`endif

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_tvalid  = vld_p1;
  assign m_tdata   = data_p1;
  assign m_tlast   = last_p1;
  assign m_tkeep   = 1'b1;
  assign seq_o     = seq;
  assign overrun_o = overrun_p1;

endmodule
